// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and the baud-rate divisor helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Divisor is rounded to the nearest whole clock.
  function automatic int clks_per_bit(input int sys_clk, input int baud);
    return (sys_clk + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered full/empty/count flags and a first-word-fall-through read port.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push;
  logic             pop;

  assign push = wr_en && !full_q;
  assign pop  = rd_en && !empty_q;

  // The extra pointer MSB separates a full ring (MSBs differ) from an empty one (pointers equal).
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + (AW + 1)'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + (AW + 1)'(1) : rd_ptr_q;
    empty_d  = (wr_ptr_d == rd_ptr_d);
    full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    count_d  = CW'(wr_ptr_d - rd_ptr_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
  assign full    = full_q;
  assign empty   = empty_q;
  assign count   = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: queued bytes are sent back-to-back at a fixed baud rate.
// Define UART_TX_PARITY_EN to insert a parity bit (sense chosen by PARITY_ODD) after the data bits.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int BAUD       = 9600,
  parameter int SYS_CLK    = 12000000,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enable,
  input  logic [DATA_BITS-1:0]            tx_input,
  input  logic                            new_data,
  output logic                            tx_wire,
  output logic                            ready,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            overflow
);

  localparam int CPB = clks_per_bit(SYS_CLK, BAUD);
  localparam int BW  = $clog2(CPB + 1);
  localparam int IW  = $clog2(DATA_BITS + 1);
`ifdef UART_TX_PARITY_EN
  localparam tx_state_t AFTER_DATA = PARITY;
`else
  localparam tx_state_t AFTER_DATA = STOP;
`endif

  tx_state_t            state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, line_d;
  logic                 busy_q;
  logic                 overflow_q;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 pop;
  logic                 bit_end;
  logic                 start_ok;

  sync_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (new_data),
    .wr_data(tx_input),
    .rd_en  (pop),
    .rd_data(fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign bit_end  = (baud_q == BW'(CPB - 1));
  assign start_ok = enable && !fifo_empty;

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    pop      = 1'b0;
    if (state_q != IDLE) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == IW'(DATA_BITS - 1)) begin
            idx_d   = '0;
            state_d = AFTER_DATA;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          idx_d   = '0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (idx_q != IW'(STOP_BITS - 1)) begin
            idx_d = idx_q + 1'b1;
          end else if (start_ok) begin
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      shift_d  = fifo_rdata;
      parity_d = (^fifo_rdata) ^ (PARITY_ODD != 0);
    end
  end

  // Line level follows the current state; registering it keeps tx_wire glitch-free.
  always_comb begin
    line_d = 1'b1;
    unique case (state_q)
      START:   line_d = 1'b0;
      DATA:    line_d = shift_q[0];
      PARITY:  line_d = parity_q;
      default: line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tx_q       <= line_d;
      busy_q     <= (state_q != IDLE);
      overflow_q <= overflow_q || (new_data && fifo_full);
    end
  end

  assign tx_wire  = tx_q;
  assign ready    = !fifo_full;
  assign busy     = busy_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised self-checking bench: a line receiver model decodes frames and compares them to a queue of written bytes.
module tb_uart_tx_fifo;

  localparam int DATA_BITS  = 8;
  localparam int BAUD       = 10;
  localparam int SYS_CLK    = 125;
  localparam int STOP_BITS  = 2;
  localparam int FIFO_DEPTH = 16;
  localparam int PARITY_ODD = 0;
  localparam int CPB        = (SYS_CLK + BAUD / 2) / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  localparam int FRAME_BITS = 1 + DATA_BITS + PBITS + STOP_BITS;
  localparam int FRAME_CLKS = FRAME_BITS * CPB;
  localparam int CW         = $clog2(FIFO_DEPTH + 1);

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 enable = 1'b0;
  logic [DATA_BITS-1:0] tx_input = '0;
  logic                 new_data = 1'b0;
  logic                 tx_wire;
  logic                 ready;
  logic                 busy;
  logic [CW-1:0]        fifo_count;
  logic                 overflow;

  uart_tx_fifo #(
    .DATA_BITS (DATA_BITS),
    .BAUD      (BAUD),
    .SYS_CLK   (SYS_CLK),
    .STOP_BITS (STOP_BITS),
    .FIFO_DEPTH(FIFO_DEPTH),
    .PARITY_ODD(PARITY_ODD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .tx_input  (tx_input),
    .new_data  (new_data),
    .tx_wire   (tx_wire),
    .ready     (ready),
    .busy      (busy),
    .fifo_count(fifo_count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;
  int cyc         = 0;
  int lastWriteCyc;
  int framesDone  = 0;
  int startQ[$];
  logic [DATA_BITS-1:0] expQ[$];

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] expectedFrame(input logic [DATA_BITS-1:0] d);
    logic [15:0] v;
    v    = '1;
    v[0] = 1'b0;
    for (int i = 0; i < DATA_BITS; i++) v[1+i] = d[i];
`ifdef UART_TX_PARITY_EN
    v[1+DATA_BITS] = (^d) ^ (PARITY_ODD != 0);
`endif
    return v;
  endfunction

  // Line receiver: a falling edge from idle opens a frame; every bit must hold for CPB clocks.
  bit          monActive = 1'b0;
  int          monCnt;
  int          monGlitch;
  int          monStartCyc;
  logic        monHeld;
  logic [15:0] monBits;
  logic        prevTx = 1'b1;

  always @(negedge clk) begin : monitor
    int b;
    logic [DATA_BITS-1:0] d;
    if (rst) begin
      monActive = 1'b0;
    end else begin
      if (!monActive && prevTx === 1'b1 && tx_wire === 1'b0) begin
        monActive   = 1'b1;
        monCnt      = 0;
        monGlitch   = 0;
        monBits     = '1;
        monStartCyc = cyc;
      end
      if (monActive) begin
        b = monCnt / CPB;
        if (monCnt % CPB == 0) monHeld = tx_wire;
        else if (tx_wire !== monHeld) monGlitch++;
        if (monCnt % CPB == CPB / 2) monBits[b] = tx_wire;
        if (monCnt == CPB / 2) checkOutput("busy_in_frame", busy, 1);
        if (monCnt == FRAME_CLKS - 1) begin
          checkOutput("frame_expected", expQ.size() > 0, 1);
          if (expQ.size() > 0) begin
            d = expQ.pop_front();
            checkOutput("frame_bits", monBits, expectedFrame(d));
          end
          checkOutput("bit_stable", monGlitch, 0);
          startQ.push_back(monStartCyc);
          framesDone++;
          monActive = 1'b0;
        end else begin
          monCnt++;
        end
      end
    end
    prevTx = tx_wire;
  end

  task automatic applyStimulus(input logic [DATA_BITS-1:0] d, input bit expectAccept);
    @(negedge clk);
    checkOutput("ready_before_write", ready, expectAccept);
    tx_input = d;
    new_data = 1'b1;
    @(posedge clk);
    #1;
    lastWriteCyc = cyc;
    new_data     = 1'b0;
    if (expectAccept) expQ.push_back(d);
  endtask

  task automatic waitFrames(input int target, input int budget);
    int n = 0;
    while (framesDone < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("frames_done", framesDone, target);
  endtask

  task automatic idleWindow(input int n);
    int highs = 0;
    int quiet = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tx_wire === 1'b1) highs++;
      if (busy === 1'b0) quiet++;
    end
    checkOutput("idle_line_high", highs, n);
    checkOutput("idle_not_busy", quiet, n);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base;
    int gaps;
    int n;
    int w;

    repeat (3) @(negedge clk);
    checkOutput("reset_tx", tx_wire, 1);
    checkOutput("reset_ready", ready, 1);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_count", fifo_count, 0);
    checkOutput("reset_overflow", overflow, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    idleWindow(20 * CPB);

    enable = 1'b1;
    applyStimulus(8'hA5, 1'b1);
    waitFrames(1, FRAME_CLKS + 20);
    if (startQ.size() > 0) checkOutput("start_latency", startQ[$] - lastWriteCyc, 2);

    for (int it = 0; it < 4; it++) begin
      base = framesDone;
      n    = $urandom_range(1, 5);
      for (int j = 0; j < n; j++) begin
        applyStimulus(DATA_BITS'($urandom_range(0, 255)), 1'b1);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      waitFrames(base + n, (n + 1) * FRAME_CLKS + 20);
    end
    repeat (3) @(negedge clk);
    checkOutput("drained_count", fifo_count, 0);
    checkOutput("drained_busy", busy, 0);

    enable = 1'b0;
    for (int i = 0; i <= FIFO_DEPTH; i++) begin
      applyStimulus(DATA_BITS'(i), i < FIFO_DEPTH);
      if (i == FIFO_DEPTH - 1) begin
        @(negedge clk);
        checkOutput("full_count", fifo_count, FIFO_DEPTH);
        checkOutput("full_ready", ready, 0);
        checkOutput("full_no_overflow", overflow, 0);
      end
    end
    @(negedge clk);
    checkOutput("overflow_set", overflow, 1);
    checkOutput("overflow_count", fifo_count, FIFO_DEPTH);
    checkOutput("overflow_line_idle", tx_wire, 1);
    base = startQ.size();
    w    = framesDone;
    enable = 1'b1;
    waitFrames(w + FIFO_DEPTH, (FIFO_DEPTH + 1) * FRAME_CLKS + 20);
    gaps = 0;
    for (int k = base + 1; k < startQ.size(); k++) begin
      if (startQ[k] - startQ[k-1] != FRAME_CLKS) gaps++;
    end
    checkOutput("burst_contiguous", gaps, 0);
    repeat (3) @(negedge clk);
    checkOutput("burst_drained", fifo_count, 0);
    checkOutput("overflow_sticky", overflow, 1);

    base = framesDone;
    for (int j = 0; j < 3; j++) applyStimulus(DATA_BITS'($urandom_range(0, 255)), 1'b1);
    w = 0;
    while (busy !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    repeat (2 * CPB) @(negedge clk);
    enable = 1'b0;
    waitFrames(base + 1, 2 * FRAME_CLKS);
    repeat (3) @(negedge clk);
    idleWindow(2 * FRAME_CLKS);
    checkOutput("held_frames", framesDone, base + 1);
    checkOutput("held_count", fifo_count, 2);
    applyStimulus(DATA_BITS'($urandom_range(0, 255)), 1'b1);
    @(negedge clk);
    checkOutput("disabled_write_count", fifo_count, 3);
    enable = 1'b1;
    waitFrames(base + 4, 4 * FRAME_CLKS + 20);

    base = framesDone;
    for (int j = 0; j < 3; j++) applyStimulus(DATA_BITS'($urandom_range(0, 255)), 1'b1);
    w = 0;
    while (!(monActive && monCnt >= 4 * CPB + CPB / 2) && w < 2 * FRAME_CLKS) begin
      @(posedge clk);
      #1;
      w++;
    end
    checkOutput("queued_before_reset", fifo_count, 2);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    expQ.delete();
    checkOutput("midreset_tx", tx_wire, 1);
    checkOutput("midreset_count", fifo_count, 0);
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_ready", ready, 1);
    checkOutput("midreset_overflow", overflow, 0);
    idleWindow(3 * FRAME_CLKS);
    checkOutput("no_frames_after_reset", framesDone, base);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered, parametrised successor to the single-byte `uart_tx` transmitter. Accepts bytes from the system side into an internal FIFO and serialises them back-to-back onto `tx_wire` at a fixed baud rate. Supports configurable data width, stop-bit count, FIFO depth and an optional parity bit. It sits between the host logic and the board UART TX pin.

## Interface
- `DATA_BITS`, 8, data bits per frame (5–9)
- `BAUD`, 9600, line rate in bit/s
- `SYS_CLK`, 12000000, `clk` frequency in Hz
- `STOP_BITS`, 1, number of stop bits (1 or 2)
- `FIFO_DEPTH`, 16, FIFO entries; must be a power of two, ≥2
- `PARITY_ODD`, 0, 0 = even parity, 1 = odd parity; only used with `UART_TX_PARITY_EN`

- `clk` in 1, system clock
- `rst` in 1, reset; synchronous, active-high
- `enable` in 1, when low, no new frame starts
- `tx_input` in DATA_BITS, byte to queue
- `new_data` in 1, write strobe; one entry is queued per cycle it is high and `ready` is high
- `tx_wire` out 1, serial line, idle high
- `ready` out 1, FIFO not full (registered)
- `busy` out 1, a frame is on the line
- `fifo_count` out $clog2(FIFO_DEPTH+1), current FIFO occupancy
- `overflow` out 1, sticky; set when `new_data` is high while `ready` is low

## Operation
- Bit period: `CLKS_PER_BIT = (SYS_CLK + BAUD/2) / BAUD`, which is 1250 at the defaults. Every line bit lasts exactly `CLKS_PER_BIT` clocks.
- FSM states: IDLE → START → DATA → [PARITY] → STOP → IDLE or START.
- IDLE:
  - `tx_wire` = 1.
  - If `enable` is high and the FIFO is non-empty, pop one entry and go to START.
- START: `tx_wire` = 0 for one bit period.
- DATA:
  - Shift out `DATA_BITS` bits, LSB first.
  - A bit index counts 0..DATA_BITS-1.
- PARITY (macro only): XOR of the data bits, inverted when `PARITY_ODD` = 1.
- STOP:
  - `tx_wire` = 1 for `STOP_BITS` bit periods.
  - At the end, if `enable` is high and the FIFO is non-empty, pop the next entry and go straight to START, with no idle gap. Otherwise go to IDLE.
- `enable` deassertion mid-frame: the current frame completes. Writes are still accepted.
- A write while full is dropped: FIFO contents are unchanged and `overflow` is set.
- Simultaneous write and pop:
  - Both take effect and `fifo_count` is unchanged.
  - When full, the write is still rejected, because `ready` reflects the registered full flag.
- `busy` is high in every state except IDLE.

## Timing
- Reset values: `tx_wire` = 1, `ready` = 1, `busy` = 0, `fifo_count` = 0, `overflow` = 0. State is IDLE and the FIFO is flushed.
- Reset mid-frame:
  - `tx_wire` returns to 1 at the next edge.
  - The partial frame is abandoned and queued data is lost.
- Latency: a write at edge N into an empty FIFO while IDLE and enabled → `tx_wire` falls at edge N+2.
- All outputs are registered. `tx_wire` never glitches within a bit period.
- Frame length: (1 + DATA_BITS + P + STOP_BITS) × CLKS_PER_BIT clocks, where P = 1 with parity, else 0.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state and parity bit are inserted after the data bits, and `PARITY_ODD` selects the sense.
- Not defined: no parity bit, the PARITY state is absent, and `PARITY_ODD` is ignored.

## Structure
- Package `uart_pkg`:
  - `tx_state_t` enum (IDLE, START, DATA, PARITY, STOP)
  - function `clks_per_bit(sys_clk, baud)`, shared with the future `uart_rx`
- Sub-module `sync_fifo`:
  - Parameters: width, depth.
  - Ports: `clk`, `rst`, write, read, full, empty, count.
  - Pointers carry one extra wrap bit to distinguish full from empty.
- Top: baud counter, bit index, shift register, FSM, sticky overflow.

## Test plan
- Reset, no writes for 1 ms → `tx_wire` constantly 1; `busy` = 0, `ready` = 1.
- Write 0xA5 at defaults → line reads 0,1,0,1,0,0,1,0,1,1. Each bit is 1250 clocks. The start bit falls 2 clocks after the write.
- `UART_TX_PARITY_EN`, write 0xA5 → parity bit 0 with `PARITY_ODD` = 0, 1 with `PARITY_ODD` = 1.
- `enable` = 0, write 17 bytes 0x00..0x10:
  - After 16 writes, `fifo_count` = 16 and `ready` = 0.
  - The 17th write sets `overflow`.
  - Then `enable` = 1 → 16 contiguous frames carrying 0x00..0x0F in order; `fifo_count` reaches 0.
- `STOP_BITS` = 2, two queued bytes → line high for exactly 2500 clocks between the last data bit and the next start bit.
- Assert `rst` for 1 cycle during the 4th data bit, with 3 bytes queued → `tx_wire` = 1 next edge, `fifo_count` = 0, no further frames.
